id_forward_stage: RTL and testbench

ID_FORWARD_STAGE -- requirements
Module: id_forward_stage

---
 rtl/id_forward_stage_pkg.sv | 110 +++++++++++
 rtl/id_forward_stage_bypass_select.sv | 47 ++++
 rtl/id_forward_stage.sv | 201 ++++++++++++++++++++
 tb/tb_id_forward_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_forward_stage_pkg.sv
// Shared types for the ID stage: inter-stage buses, the bypass source record,
// instruction encodings, ALU one-hot bit positions and the operand-use decode.
package id_stage_params;

    localparam int DEFAULT_NUM_BYPASS        = 3;
    localparam int DEFAULT_STALL_COUNT_WIDTH = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Bit positions inside the 12-bit one-hot alu_operation field.
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic        valid;
        logic [31:0] instruction;
        logic [31:0] program_count;
    } IFToIDInstructionBusData;

    typedef struct packed {
        logic        write_enable;
        logic [4:0]  write_register;
        logic [31:0] write_data;
    } WBToRegisterFileData;

    typedef struct packed {
        logic        valid;
        logic [11:0] alu_operation;
        logic        src1_is_shift_amount;
        logic        src1_is_pc;
        logic        src2_is_immediate;
        logic        src2_is_8;
        logic        memory_read;
        logic        memory_write;
        logic        register_write;
        logic [4:0]  write_register;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] immediate;
        logic [31:0] program_count;
    } IDToEXDecodeBusData;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } IDToIFBranchBusData;

    typedef struct packed {
        logic        valid;
        logic [4:0]  write_register;
        logic [31:0] write_data;
        logic        data_ready;
    } bypass_source_t;

    typedef struct packed {
        logic rs_used;
        logic rt_used;
    } operand_use_t;

    // An operand counts only if the instruction actually reads it, so a
    // pending write to an ignored field never stalls the stage.
    function automatic operand_use_t operand_use(input logic [31:0] instruction);
        logic [5:0]   op;
        logic [5:0]   fn;
        logic         is_alu_r;
        logic         is_shift;
        logic         is_jr;
        operand_use_t result;
        op       = instruction[31:26];
        fn       = instruction[5:0];
        is_alu_r = (op == OP_SPECIAL) && (fn inside {FN_ADDU, FN_SUBU, FN_SLT, FN_SLTU,
                                                     FN_AND, FN_OR, FN_XOR, FN_NOR});
        is_shift = (op == OP_SPECIAL) && (fn inside {FN_SLL, FN_SRL, FN_SRA});
        is_jr    = (op == OP_SPECIAL) && (fn == FN_JR);
        result.rs_used = is_alu_r || is_jr || (op inside {OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE});
        result.rt_used = is_alu_r || is_shift || (op inside {OP_SW, OP_BEQ, OP_BNE});
        return result;
    endfunction

endpackage

// File: rtl/id_forward_stage_bypass_select.sv
// Resolves one source operand against the back-pass sources (index 0 youngest).
// Forwarding is enabled by ID_FORWARD_STAGE_BYPASS_EN; otherwise any match stalls.
module bypass_select
    import id_stage_params::*;
#(
    parameter int NUM_BYPASS = DEFAULT_NUM_BYPASS
) (
    input  logic                             operand_used,
    input  logic [4:0]                       read_register,
    input  logic [31:0]                      register_file_data,
    input  bypass_source_t [NUM_BYPASS-1:0]  sources,
    output logic [31:0]                      operand_value,
    output logic                             operand_stall
);

    logic        hit;
    logic        hit_ready;
    logic [31:0] hit_data;

    // NOTE: every signal written here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b1;
        hit_data  = register_file_data;
        // Walk oldest to youngest so the lowest matching index wins.
        for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
            if (sources[i].valid && (sources[i].write_register == read_register) &&
                (read_register != 5'd0)) begin
                hit       = 1'b1;
                hit_ready = sources[i].data_ready;
                hit_data  = sources[i].write_data;
            end
        end
    end

`ifdef ID_FORWARD_STAGE_BYPASS_EN
    assign operand_value = (read_register == 5'd0) ? 32'd0 : hit_data;
    assign operand_stall = operand_used && hit && !hit_ready;
`else
    logic unused_bypass_payload;
    assign unused_bypass_payload = ^{hit_data, hit_ready};
    assign operand_value = (read_register == 5'd0) ? 32'd0 : register_file_data;
    assign operand_stall = operand_used && hit;
`endif

endmodule

// File: rtl/id_forward_stage.sv
// MIPS-subset decode stage with register file, hazard stall and operand bypass.
// Optional forwarding: define ID_FORWARD_STAGE_BYPASS_EN.
module id_forward_stage
    import id_stage_params::*;
#(
    parameter int NUM_BYPASS        = DEFAULT_NUM_BYPASS,
    parameter int STALL_COUNT_WIDTH = DEFAULT_STALL_COUNT_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ex_allow_in,
    output logic                          id_allow_in,
    input  IFToIDInstructionBusData       if_to_id_instruction_bus,
    input  logic [NUM_BYPASS-1:0]         back_pass_valid,
    input  logic [5*NUM_BYPASS-1:0]       back_pass_write_register,
    input  logic [32*NUM_BYPASS-1:0]      back_pass_write_data,
    input  logic [NUM_BYPASS-1:0]         back_pass_data_ready,
    input  WBToRegisterFileData           wb_to_register_file_bus,
    output IDToEXDecodeBusData            id_to_ex_decode_bus,
    output IDToIFBranchBusData            id_to_if_branch_bus,
    output logic [STALL_COUNT_WIDTH-1:0]  stall_count
);

    logic                         id_valid_q, id_valid_d;
    logic [31:0]                  instruction_q;
    logic [31:0]                  program_count_q;
    logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [31:0]                  reg_file_q [32];
    logic                         id_ready_go;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] jump_index;
    assign opcode     = instruction_q[31:26];
    assign rs         = instruction_q[25:21];
    assign rt         = instruction_q[20:16];
    assign rd         = instruction_q[15:11];
    assign sa         = instruction_q[10:6];
    assign funct      = instruction_q[5:0];
    assign imm        = instruction_q[15:0];
    assign jump_index = instruction_q[25:0];

    // Register file: written from WB, read combinationally with write-through.
    // NOTE: the storage array has no reset; software never reads a register
    // before writing it, and $0 is forced to zero at the read side.
    always_ff @(posedge clock) begin
        if (wb_to_register_file_bus.write_enable && (wb_to_register_file_bus.write_register != 5'd0))
            reg_file_q[wb_to_register_file_bus.write_register] <= wb_to_register_file_bus.write_data;
    end

    logic [31:0] rs_file_data, rt_file_data;
    always_comb begin
        rs_file_data = reg_file_q[rs];
        rt_file_data = reg_file_q[rt];
        if (wb_to_register_file_bus.write_enable && (wb_to_register_file_bus.write_register == rs))
            rs_file_data = wb_to_register_file_bus.write_data;
        if (wb_to_register_file_bus.write_enable && (wb_to_register_file_bus.write_register == rt))
            rt_file_data = wb_to_register_file_bus.write_data;
    end

    bypass_source_t [NUM_BYPASS-1:0] sources;
    for (genvar g = 0; g < NUM_BYPASS; g++) begin : g_pack_sources
        assign sources[g] = '{valid:          back_pass_valid[g],
                              write_register: back_pass_write_register[5*g +: 5],
                              write_data:     back_pass_write_data[32*g +: 32],
                              data_ready:     back_pass_data_ready[g]};
    end

    operand_use_t operands_used;
    logic [31:0]  rs_value, rt_value;
    logic         rs_stall, rt_stall;
    assign operands_used = operand_use(instruction_q);

    bypass_select #(.NUM_BYPASS(NUM_BYPASS)) u_rs_select (
        .operand_used       (operands_used.rs_used),
        .read_register      (rs),
        .register_file_data (rs_file_data),
        .sources            (sources),
        .operand_value      (rs_value),
        .operand_stall      (rs_stall)
    );

    bypass_select #(.NUM_BYPASS(NUM_BYPASS)) u_rt_select (
        .operand_used       (operands_used.rt_used),
        .read_register      (rt),
        .register_file_data (rt_file_data),
        .sources            (sources),
        .operand_value      (rt_value),
        .operand_stall      (rt_stall)
    );

    assign id_ready_go = !(rs_stall || rt_stall);
    assign id_allow_in = !id_valid_q || (id_ready_go && ex_allow_in);

    logic is_special;
    logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
    logic inst_sll, inst_srl, inst_sra, inst_jr;
    logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;
    logic inst_known;
    assign is_special = (opcode == OP_SPECIAL);
    assign inst_addu  = is_special && (funct == FN_ADDU);
    assign inst_subu  = is_special && (funct == FN_SUBU);
    assign inst_slt   = is_special && (funct == FN_SLT);
    assign inst_sltu  = is_special && (funct == FN_SLTU);
    assign inst_and   = is_special && (funct == FN_AND);
    assign inst_or    = is_special && (funct == FN_OR);
    assign inst_xor   = is_special && (funct == FN_XOR);
    assign inst_nor   = is_special && (funct == FN_NOR);
    assign inst_sll   = is_special && (funct == FN_SLL);
    assign inst_srl   = is_special && (funct == FN_SRL);
    assign inst_sra   = is_special && (funct == FN_SRA);
    assign inst_jr    = is_special && (funct == FN_JR);
    assign inst_addiu = (opcode == OP_ADDIU);
    assign inst_lui   = (opcode == OP_LUI);
    assign inst_lw    = (opcode == OP_LW);
    assign inst_sw    = (opcode == OP_SW);
    assign inst_beq   = (opcode == OP_BEQ);
    assign inst_bne   = (opcode == OP_BNE);
    assign inst_jal   = (opcode == OP_JAL);
    assign inst_known = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or |
                        inst_xor | inst_nor | inst_sll | inst_srl | inst_sra | inst_jr |
                        inst_addiu | inst_lui | inst_lw | inst_sw | inst_beq | inst_bne | inst_jal;

    logic [31:0] pc_plus_4, branch_target, jal_target;
    logic        operands_equal;
    assign pc_plus_4      = program_count_q + 32'd4;
    assign branch_target  = pc_plus_4 + {{14{imm[15]}}, imm, 2'b00};
    assign jal_target     = {pc_plus_4[31:28], jump_index, 2'b00};
    assign operands_equal = (rs_value == rt_value);

    always_comb begin
        id_to_if_branch_bus        = '0;
        id_to_if_branch_bus.taken  = id_valid_q && id_ready_go &&
                                     ((inst_beq && operands_equal) || (inst_bne && !operands_equal) ||
                                      inst_jal || inst_jr);
        id_to_if_branch_bus.target = inst_jr  ? rs_value :
                                     inst_jal ? jal_target : branch_target;
    end

    always_comb begin
        id_to_ex_decode_bus                          = '0;
        id_to_ex_decode_bus.valid                    = id_valid_q && id_ready_go;
        id_to_ex_decode_bus.alu_operation[ALU_ADD]   = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
        id_to_ex_decode_bus.alu_operation[ALU_SUB]   = inst_subu;
        id_to_ex_decode_bus.alu_operation[ALU_SLT]   = inst_slt;
        id_to_ex_decode_bus.alu_operation[ALU_SLTU]  = inst_sltu;
        id_to_ex_decode_bus.alu_operation[ALU_AND]   = inst_and;
        id_to_ex_decode_bus.alu_operation[ALU_NOR]   = inst_nor;
        id_to_ex_decode_bus.alu_operation[ALU_OR]    = inst_or;
        id_to_ex_decode_bus.alu_operation[ALU_XOR]   = inst_xor;
        id_to_ex_decode_bus.alu_operation[ALU_SLL]   = inst_sll;
        id_to_ex_decode_bus.alu_operation[ALU_SRL]   = inst_srl;
        id_to_ex_decode_bus.alu_operation[ALU_SRA]   = inst_sra;
        id_to_ex_decode_bus.alu_operation[ALU_LUI]   = inst_lui;
        id_to_ex_decode_bus.src1_is_shift_amount     = inst_sll | inst_srl | inst_sra;
        id_to_ex_decode_bus.src1_is_pc               = inst_jal;
        id_to_ex_decode_bus.src2_is_immediate        = inst_addiu | inst_lui | inst_lw | inst_sw;
        id_to_ex_decode_bus.src2_is_8                = inst_jal;
        id_to_ex_decode_bus.memory_read              = inst_lw;
        id_to_ex_decode_bus.memory_write             = inst_sw;
        id_to_ex_decode_bus.register_write           = inst_known && !(inst_sw | inst_beq | inst_bne | inst_jr);
        id_to_ex_decode_bus.write_register           = inst_jal ? 5'd31 :
                                                       (inst_addiu | inst_lui | inst_lw) ? rt : rd;
        id_to_ex_decode_bus.rs_value                 = rs_value;
        id_to_ex_decode_bus.rt_value                 = rt_value;
        // Shifts carry sa in the immediate; lui zero-extends, everything else sign-extends.
        id_to_ex_decode_bus.immediate                = (inst_sll | inst_srl | inst_sra) ? {27'd0, sa} :
                                                       inst_lui ? {16'd0, imm} : {{16{imm[15]}}, imm};
        id_to_ex_decode_bus.program_count            = program_count_q;
    end

    always_comb begin
        id_valid_d    = id_allow_in ? if_to_id_instruction_bus.valid : id_valid_q;
        stall_count_d = stall_count_q;
        if (id_valid_q && !id_ready_go && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            id_valid_q    <= id_valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (if_to_id_instruction_bus.valid && id_allow_in) begin
            instruction_q   <= if_to_id_instruction_bus.instruction;
            program_count_q <= if_to_id_instruction_bus.program_count;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_forward_stage.sv
// Directed bench for id_forward_stage; expectations adapt to ID_FORWARD_STAGE_BYPASS_EN.
module tb_id_forward_stage;
    import id_stage_params::*;

    localparam int NB = 3;
    localparam int SW = 4;
`ifdef ID_FORWARD_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] ADDU_T1_T0_ZERO = 32'h0100_4821;
    localparam logic [31:0] BEQ_T0_T1_4     = 32'h1109_0004;
    localparam logic [31:0] JR_RA           = 32'h03E0_0008;
    localparam logic [31:0] ADDIU_T1_ZERO_1 = 32'h2409_0001;
    localparam logic [31:0] JAL_100000      = 32'h0C10_0000;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    ex_allow_in;
    logic                    id_allow_in;
    IFToIDInstructionBusData if_bus;
    logic [NB-1:0]           bp_valid;
    logic [5*NB-1:0]         bp_reg;
    logic [32*NB-1:0]        bp_data;
    logic [NB-1:0]           bp_ready;
    WBToRegisterFileData     wb_bus;
    IDToEXDecodeBusData      dec;
    IDToIFBranchBusData      br;
    logic [SW-1:0]           stall_count;

    int tests = 0;
    int fails = 0;

    id_forward_stage #(.NUM_BYPASS(NB), .STALL_COUNT_WIDTH(SW)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .ex_allow_in              (ex_allow_in),
        .id_allow_in              (id_allow_in),
        .if_to_id_instruction_bus (if_bus),
        .back_pass_valid          (bp_valid),
        .back_pass_write_register (bp_reg),
        .back_pass_write_data     (bp_data),
        .back_pass_data_ready     (bp_ready),
        .wb_to_register_file_bus  (wb_bus),
        .id_to_ex_decode_bus      (dec),
        .id_to_if_branch_bus      (br),
        .stall_count              (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_source(input int idx, input logic v, input logic [4:0] r,
                              input logic [31:0] d, input logic rdy);
        bp_valid[idx]        = v;
        bp_reg[5*idx +: 5]   = r;
        bp_data[32*idx +: 32] = d;
        bp_ready[idx]        = rdy;
    endtask

    task automatic clear_sources();
        bp_valid = '0;
        bp_reg   = '0;
        bp_data  = '0;
        bp_ready = '0;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        if_bus = '{valid: 1'b1, instruction: instr, program_count: pc};
        tick();
        if_bus.valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        ex_allow_in = 1'b1;
        if_bus      = '0;
        wb_bus      = '0;
        clear_sources();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_allow", id_allow_in, 1);
        check("rst_valid", dec.valid, 0);
        check("rst_taken", br.taken, 0);
        check("rst_count", stall_count, 0);

        // Register file: $t0=0x3, $t1=0x10, $ra=0x400
        wb_bus = '{write_enable: 1'b1, write_register: 5'd8, write_data: 32'h3};
        tick();
        wb_bus = '{write_enable: 1'b1, write_register: 5'd9, write_data: 32'h10};
        tick();
        wb_bus = '{write_enable: 1'b1, write_register: 5'd31, write_data: 32'h400};
        tick();
        wb_bus = '0;

        // Youngest matching source wins
        set_source(1, 1, 5'd8, 32'h5, 1);
        set_source(0, 1, 5'd8, 32'h7, 1);
        load(ADDU_T1_T0_ZERO, 32'h2000);
        check("s1_valid", dec.valid, BYP);
        check("s1_rs", dec.rs_value, BYP ? 32'h7 : 32'h3);
        check("s1_rt", dec.rt_value, 32'h0);
        clear_sources();
        #1;
        check("s1_valid_clear", dec.valid, 1);
        check("s1_rs_clear", dec.rs_value, 32'h3);
        check("s1_wreg", dec.write_register, 9);
        check("s1_regwrite", dec.register_write, 1);
        check("s1_aluop", dec.alu_operation, 32'h001);
        tick();

        // Load-use: source 0 not ready for two cycles
        set_source(0, 1, 5'd8, 32'h55, 0);
        load(ADDU_T1_T0_ZERO, 32'h2004);
        check("s2_c1_valid", dec.valid, 0);
        check("s2_c1_allow", id_allow_in, 0);
        tick();
        check("s2_c2_valid", dec.valid, 0);
        check("s2_cnt1", stall_count, 1);
        tick();
        set_source(0, 1, 5'd8, 32'h55, 1);
        #1;
        check("s2_cnt2", stall_count, 2);
        check("s2_c3_valid", dec.valid, BYP);
        check("s2_c3_rs", dec.rs_value, BYP ? 32'h55 : 32'h3);
        tick();
        clear_sources();
        #1;
        check("s2_allow_after", id_allow_in, 1);
        tick();
        check("s2_cnt_final", stall_count, BYP ? 2 : 3);
        check("s2_drained", dec.valid, 0);

        // beq with forwarded $t0
        set_source(0, 1, 5'd8, 32'h10, 1);
        load(BEQ_T0_T1_4, 32'h1000);
        check("s3_taken", br.taken, BYP);
        check("s3_target", br.target, 32'h1014);
        check("s3_regwrite", dec.register_write, 0);
        clear_sources();
        #1;
        check("s3_untaken", br.taken, 0);
        tick();

        // jr with forwarded $ra, ready then not ready
        set_source(0, 1, 5'd31, 32'hBFC0_0100, 1);
        load(JR_RA, 32'h3000);
        check("s4_taken", br.taken, BYP);
        check("s4_target", br.target, BYP ? 32'hBFC0_0100 : 32'h400);
        clear_sources();
        #1;
        check("s4_taken_rf", br.taken, 1);
        check("s4_target_rf", br.target, 32'h400);
        tick();
        set_source(0, 1, 5'd31, 32'hBFC0_0100, 0);
        load(JR_RA, 32'h3000);
        check("s4_nr_taken", br.taken, 0);
        tick();
        check("s4_nr_taken2", br.taken, 0);
        check("s4_nr_cnt", stall_count, BYP ? 3 : 4);
        set_source(0, 1, 5'd31, 32'hBFC0_0100, 1);
        #1;
        check("s4_rdy_taken", br.taken, BYP);
        check("s4_rdy_target", br.target, BYP ? 32'hBFC0_0100 : 32'h400);
        clear_sources();
        #1;
        check("s4_clr_taken", br.taken, 1);
        tick();

        // Matches on $0 and on the unused rt of addiu never stall
        set_source(0, 1, 5'd9, 32'h0, 0);
        set_source(1, 1, 5'd0, 32'h0, 0);
        load(ADDIU_T1_ZERO_1, 32'h4000);
        check("s5_valid", dec.valid, 1);
        check("s5_rs", dec.rs_value, 0);
        check("s5_wreg", dec.write_register, 9);
        check("s5_imm", dec.immediate, 1);
        tick();
        clear_sources();

        // Only an older source matches
        set_source(2, 1, 5'd8, 32'h99, 1);
        load(ADDU_T1_T0_ZERO, 32'h4004);
        check("s5_old_valid", dec.valid, BYP);
        check("s5_old_rs", dec.rs_value, BYP ? 32'h99 : 32'h3);
        tick();
        check("s5_cnt", stall_count, BYP ? 3 : 5);
        clear_sources();
        tick();

        // Younger ready source hides an older not-ready one
        set_source(0, 1, 5'd8, 32'h7, 1);
        set_source(1, 1, 5'd8, 32'h0, 0);
        load(ADDU_T1_T0_ZERO, 32'h4008);
        check("s5_prio_valid", dec.valid, BYP);
        check("s5_prio_rs", dec.rs_value, BYP ? 32'h7 : 32'h3);
        clear_sources();
        tick();

        // Same-cycle register file write and back-pass to $t0
        set_source(0, 1, 5'd8, 32'hBB, 1);
        load(ADDU_T1_T0_ZERO, 32'h5000);
        wb_bus = '{write_enable: 1'b1, write_register: 5'd8, write_data: 32'hAA};
        #1;
        check("s6_rs", dec.rs_value, BYP ? 32'hBB : 32'hAA);
        clear_sources();
        #1;
        check("s6_rs_wb", dec.rs_value, 32'hAA);
        tick();
        wb_bus = '0;

        // jal, with EX back-pressure
        ex_allow_in = 1'b0;
        load(JAL_100000, 32'h1000);
        check("s7_taken", br.taken, 1);
        check("s7_target", br.target, 32'h0040_0000);
        check("s7_wreg", dec.write_register, 31);
        check("s7_regwrite", dec.register_write, 1);
        check("s7_allow_blocked", id_allow_in, 0);
        tick();
        check("s7_held", dec.valid, 1);
        ex_allow_in = 1'b1;
        #1;
        check("s7_allow", id_allow_in, 1);
        tick();

        // Continuous stall saturates the counter; reset discards the held instruction
        set_source(0, 1, 5'd8, 32'h0, 0);
        load(ADDU_T1_T0_ZERO, 32'h6000);
        for (int i = 0; i < 15; i++) tick();
        check("s8_sat", stall_count, 4'hF);
        tick();
        check("s8_sat_hold", stall_count, 4'hF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("s8_rst_cnt", stall_count, 0);
        check("s8_rst_allow", id_allow_in, 1);
        check("s8_rst_valid", dec.valid, 0);
        clear_sources();
        tick();
        check("s8_discard", dec.valid, 0);
        check("s8_discard_taken", br.taken, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
